// File: rtl/rram_crossbar_mac.sv
// Behavioural RRAM crossbar with a command handshake, single-row write/read,
// multi-row MAC and a back-pressured, column-multiplexed ADC readout.
// Optional feature macro: RRAM_XBAR_ADC_SAT_EN selects saturating ADC
// quantisation; when it is undefined, column sums wrap to their low ADC_BITS bits.
`default_nettype none

module rram_crossbar_mac #(
    parameter int ROWS     = 1024,
    parameter int COLS     = 512,
    parameter int NUM_ADCS = 32,
    parameter int ADC_BITS = 4,
    localparam int CPA     = COLS / NUM_ADCS,
    localparam int PW      = (CPA > 1) ? $clog2(CPA) : 1
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CMD_VALID,
    output logic                         CMD_READY,
    input  logic [1:0]                   CMD_OP,
    input  logic [ROWS-1:0]              WL,
    input  logic [COLS-1:0]              BL,
    output logic                         ADC_VALID,
    input  logic                         ADC_READY,
    output logic [PW-1:0]                ADC_PHASE,
    output logic                         ADC_LAST,
    output logic [NUM_ADCS*ADC_BITS-1:0] ADCout,
    output logic                         ERR
);

    localparam int SW = $clog2(ROWS + 1);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ADC_MAX = (32'd1 << ADC_BITS) - 32'd1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_MAC   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_SENSE   = 2'd2,
        ST_CONVERT = 2'd3
    } state_t;

    // Exactly-one-bit-set test used to validate WRITE/READ wordline vectors
    function automatic logic is_onehot(input logic [ROWS-1:0] v);
        logic [SW-1:0] n;
        n = {SW{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            n = n + SW'(v[i]);
        end
        return (n == SW'(1));
    endfunction

    // ADC transfer function applied to a raw column bit count
    function automatic logic [ADC_BITS-1:0] quant(input logic [SW-1:0] s);
`ifdef RRAM_XBAR_ADC_SAT_EN
        if (32'(s) > ADC_MAX) begin
            return ADC_BITS'(ADC_MAX);
        end else begin
            return ADC_BITS'(s);
        end
`else
        return ADC_BITS'(s);
`endif
    endfunction

    state_t                        state_q, state_d;
    logic [ROWS-1:0]               wl_q, wl_d;
    logic [COLS-1:0]               bl_q, bl_d;
    logic                          err_q, err_d;
    logic [PW-1:0]                 phase_q, phase_d;
    logic                          valid_q, valid_d;
    logic                          last_q, last_d;
    logic                          ready_q, ready_d;
    logic [NUM_ADCS*ADC_BITS-1:0]  adc_q, adc_d;
    logic [CW-1:0]                 col_idx_s;

    logic [COLS-1:0]               mem_q     [ROWS];
    logic [ADC_BITS-1:0]           sl_acc_q  [COLS];
    logic [ADC_BITS-1:0]           sl_acc_d  [COLS];
    logic [ADC_BITS-1:0]           sense_s   [COLS];
    logic [SW-1:0]                 col_sum_s [COLS];

    // Per-column count of active wordlines hitting a set cell, then quantised
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_sum_s[c] = {SW{1'b0}};
            for (int r = 0; r < ROWS; r++) begin
                col_sum_s[c] = col_sum_s[c] + SW'(wl_q[r] & mem_q[r][c]);
            end
            sense_s[c] = quant(col_sum_s[c]);
        end
    end

    // Next-state logic for the command FSM, column results and readout registers
    always_comb begin
        state_d   = state_q;
        wl_d      = wl_q;
        bl_d      = bl_q;
        err_d     = err_q;
        phase_d   = phase_q;
        col_idx_s = {CW{1'b0}};
        adc_d     = {(NUM_ADCS*ADC_BITS){1'b0}};
        for (int c = 0; c < COLS; c++) begin
            sl_acc_d[c] = sl_acc_q[c];
        end

        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    wl_d  = WL;
                    bl_d  = BL;
                    err_d = 1'b0;
                    case (CMD_OP)
                        OP_WRITE: begin
                            if (is_onehot(WL)) begin
                                state_d = ST_WRITE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_READ: begin
                            if (is_onehot(WL)) begin
                                state_d = ST_SENSE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_MAC: begin
                            state_d = ST_SENSE;
                        end
                        OP_NOP: begin
                            state_d = ST_IDLE;
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            ST_SENSE: begin
                for (int c = 0; c < COLS; c++) begin
                    sl_acc_d[c] = sense_s[c];
                end
                phase_d = {PW{1'b0}};
                state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (ADC_READY) begin
                    if (phase_q == PW'(CPA - 1)) begin
                        phase_d = {PW{1'b0}};
                        state_d = ST_IDLE;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = {PW{1'b0}};
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with it
        valid_d = (state_d == ST_CONVERT);
        ready_d = (state_d == ST_IDLE);
        last_d  = valid_d && (phase_d == PW'(CPA - 1));
        for (int a = 0; a < NUM_ADCS; a++) begin
            col_idx_s = CW'(a * CPA) + CW'(phase_d);
            if (valid_d) begin
                adc_d[a*ADC_BITS +: ADC_BITS] = sl_acc_d[col_idx_s];
            end else begin
                adc_d[a*ADC_BITS +: ADC_BITS] = {ADC_BITS{1'b0}};
            end
        end
    end

    // Command FSM state, latched command fields and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            wl_q    <= {ROWS{1'b0}};
            bl_q    <= {COLS{1'b0}};
            err_q   <= 1'b0;
            phase_q <= {PW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            adc_q   <= {(NUM_ADCS*ADC_BITS){1'b0}};
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            bl_q    <= bl_d;
            err_q   <= err_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            adc_q   <= adc_d;
        end
    end

    // Cell array and per-column result storage; a write lands one edge after acceptance
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int r = 0; r < ROWS; r++) begin
                mem_q[r] <= {COLS{1'b0}};
            end
            for (int c = 0; c < COLS; c++) begin
                sl_acc_q[c] <= {ADC_BITS{1'b0}};
            end
        end else begin
            if (state_q == ST_WRITE) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (wl_q[r]) begin
                        mem_q[r] <= bl_q;
                    end
                end
            end
            for (int c = 0; c < COLS; c++) begin
                sl_acc_q[c] <= sl_acc_d[c];
            end
        end
    end

    assign CMD_READY = ready_q;
    assign ADC_VALID = valid_q;
    assign ADC_PHASE = phase_q;
    assign ADC_LAST  = last_q;
    assign ADCout    = adc_q;
    assign ERR       = err_q;

endmodule

`default_nettype wire

// File: doc/rram_crossbar_mac.md
# rram_crossbar_mac

Parametrised behavioural RRAM crossbar with a command handshake and a sequenced, back-pressured ADC readout. Supports single-row write, single-row read and multi-row MAC (per-column bit count across all active wordlines). Column sums are quantised to ADC_BITS and streamed out one column-mux phase at a time. It replaces the fixed 1024x1024, 32-ADC crossbar model in the accelerator datapath.

## Interface
- ROWS, default 1024: wordline count.
- COLS, default 512: source-line (column) count. Must be a multiple of NUM_ADCS.
- NUM_ADCS, default 32: ADC count. Local CPA = COLS/NUM_ADCS, the columns multiplexed per ADC.
- ADC_BITS, default 4: ADC output width.

- CLK  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  block can accept a command.
- CMD_OP  in  2  command code: 00 NOP, 01 WRITE, 10 READ, 11 MAC.
- WL  in  ROWS  wordline vector. One-hot for WRITE/READ; any pattern for MAC.
- BL  in  COLS  write data for WRITE.
- ADC_VALID  out  1  ADCout is valid for ADC_PHASE.
- ADC_READY  in  1  consumer accepts the current phase.
- ADC_PHASE  out  clog2(CPA)  current column-mux phase.
- ADC_LAST  out  1  ADC_VALID and ADC_PHASE==CPA-1.
- ADCout  out  NUM_ADCS*ADC_BITS  flat ADC outputs; ADC a occupies bits [a*ADC_BITS +: ADC_BITS].
- ERR  out  1  last accepted command was malformed.

## Operation
- Storage: mem[ROWS][COLS] bits. SL_ACC[COLS] holds ADC_BITS-wide column results.
- FSM states: IDLE, WRITE, SENSE, CONVERT. CMD_READY = (state==IDLE).
- Accept: a command is accepted on a rising edge with CMD_VALID & CMD_READY. CMD_OP, WL and BL are latched. ERR is cleared, then set again if this command is malformed.
- NOP: consumed; stays IDLE; no other effect.
- WRITE with one-hot WL: IDLE->WRITE. The next edge does mem[row] <= BL, then WRITE->IDLE.
- READ or MAC: IDLE->SENSE. The next edge loads, for every column c, SL_ACC[c] <= Q(sum over r with WL[r] of mem[r][c]). Then SENSE->CONVERT with phase=0.
  - The sum width is clog2(ROWS+1).
  - Q is defined under Configuration.
  - READ is the one-row case, so results are 0 or 1.
- CONVERT: ADC_VALID=1. ADCout[a] = SL_ACC[a*CPA + ADC_PHASE].
  - On ADC_VALID & ADC_READY, phase increments.
  - When phase CPA-1 is accepted, CONVERT->IDLE and phase resets to 0.
  - While ADC_READY=0, ADC_PHASE and ADCout are held.
- Malformed command: WRITE or READ whose WL is not exactly one-hot.
  - The command is consumed and ERR is set.
  - The FSM stays IDLE; memory is unchanged and there is no ADC output.
- MAC with WL all-zero is legal: all results are 0.
- When ADC_VALID=0, ADCout is all-zero and ADC_LAST=0.
- RESET asserted (asynchronous, any state):
  - state IDLE; mem all 0; SL_ACC all 0; phase 0.
  - Outputs: CMD_READY=1, ADC_VALID=0, ADC_PHASE=0, ADC_LAST=0, ADCout=0, ERR=0.
  - An in-progress conversion is aborted without completing.

## Timing
- Acceptance edge = E0.
- WRITE: memory is updated at E1. CMD_READY is high again after E1. A command accepted at E1 or later sees the new data. Peak write rate is one per 2 cycles.
- READ/MAC: SL_ACC is loaded at E1, and ADC_VALID rises after E1 with phase 0.
  - With ADC_READY held high, phase k is presented after E(1+k).
  - The block is IDLE after E(1+CPA).
- ERR is updated at the acceptance edge and holds until the next acceptance.
- Memory is sampled at the SENSE edge. No write can overlap a sense, because only one command is in flight.

## Configuration
- RRAM_XBAR_ADC_SAT_EN defined: Q saturates, giving min(sum, 2^ADC_BITS-1).
- RRAM_XBAR_ADC_SAT_EN undefined: Q wraps, giving sum mod 2^ADC_BITS (low ADC_BITS bits).

## Test plan
Bench parameters: ROWS=16, COLS=16, NUM_ADCS=4, ADC_BITS=4, CPA=4.
- Reset then READ WL=0x0008, ADC_READY=1 -> 4 phases with ADCout=0; ADC_LAST only on phase 3; ERR=0; CMD_READY returns high afterwards.
- WRITE WL=0x0004 BL=0x000F, then READ WL=0x0004 -> ADC0=1 in phases 0-3; ADC1-3=0. First ADC_VALID appears 1 edge after the READ acceptance.
- WRITE rows 0-15 each with BL=0xFFFF, then MAC WL=0xFFFF -> every ADC output is 15 with the macro defined and 0 with it undefined. MAC WL=0x003F -> every output is 6 in both builds.
- During CONVERT, drop ADC_READY for 3 cycles at phase 1 -> ADC_PHASE stays 1, ADCout is stable and CMD_READY=0. Conversion resumes at phase 2 after ADC_READY rises.
- WRITE WL=0x0003 BL=0xFFFF -> ERR=1. A following READ WL=0x0001 -> ERR=0 and all outputs 0. READ WL=0x0000 -> ERR=1 and no ADC_VALID.
- Assert RESET asynchronously mid-phase 2 of a MAC -> ADC_VALID=0, ADCout=0, CMD_READY=1 immediately, without waiting for a clock edge. A subsequent READ of any row returns all 0.
